header_param_sequencer: RTL and testbench

Sequences parameter checking for the camera decoder header path. It accepts one parsed header parameter set at a time from the header parser over a valid/ready handshake, holds it stable on the `chk_*` bus that feeds the external `parameter_validator`, and waits for that validator's registered verdict. A passing set is committed as the active decoder configuration (`cfg_*`); a failing or timed-out set is rejected and counted. It sits between the header parser and the pixel/tile datapath configuration registers.

---
 rtl/header_param_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_header_param_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/header_param_sequencer.sv
// ============================================================================
// header_param_sequencer
// Holds one parsed header set on the validator bus and commits or rejects it
// based on the registered verdict. HDR_SEQ_TIMEOUT_EN enables the CHECK timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module header_param_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [7:0]  hdr_profile,
    input  logic [15:0] hdr_width,
    input  logic [15:0] hdr_height,
    input  logic [7:0]  hdr_fps,
    input  logic [1:0]  hdr_chroma_format,
    input  logic [3:0]  hdr_bit_depth,
    input  logic [5:0]  hdr_qp,
    input  logic        hdr_tiles_enabled,
    input  logic [3:0]  hdr_tile_cols,
    input  logic [3:0]  hdr_tile_rows,
    output logic [7:0]  chk_profile,
    output logic [15:0] chk_width,
    output logic [15:0] chk_height,
    output logic [7:0]  chk_fps,
    output logic [1:0]  chk_chroma_format,
    output logic [3:0]  chk_bit_depth,
    output logic [5:0]  chk_qp,
    output logic        chk_tiles_enabled,
    output logic [3:0]  chk_tile_cols,
    output logic [3:0]  chk_tile_rows,
    input  logic        chk_valid,
    input  logic        chk_done,
    output logic [7:0]  cfg_profile,
    output logic [15:0] cfg_width,
    output logic [15:0] cfg_height,
    output logic [7:0]  cfg_fps,
    output logic [1:0]  cfg_chroma_format,
    output logic [3:0]  cfg_bit_depth,
    output logic [5:0]  cfg_qp,
    output logic        cfg_tiles_enabled,
    output logic [3:0]  cfg_tile_cols,
    output logic [3:0]  cfg_tile_rows,
    output logic        cfg_valid,
    output logic        cfg_update,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int SET_W = 69;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   hdr_set;
    logic [SET_W-1:0]   chk_q, chk_d;
    logic [SET_W-1:0]   cfg_q, cfg_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               cfg_update_q, cfg_update_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [7:0]         err_count_q, err_count_d;
    logic [7:0]         err_count_inc;

    // Fields are carried as one packed word; order matches the port list.
    assign hdr_set = {hdr_profile, hdr_width, hdr_height, hdr_fps, hdr_chroma_format,
                      hdr_bit_depth, hdr_qp, hdr_tiles_enabled, hdr_tile_cols, hdr_tile_rows};

    assign {chk_profile, chk_width, chk_height, chk_fps, chk_chroma_format,
            chk_bit_depth, chk_qp, chk_tiles_enabled, chk_tile_cols, chk_tile_rows} = chk_q;

    assign {cfg_profile, cfg_width, cfg_height, cfg_fps, cfg_chroma_format,
            cfg_bit_depth, cfg_qp, cfg_tiles_enabled, cfg_tile_cols, cfg_tile_rows} = cfg_q;

    assign hdr_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign cfg_valid     = cfg_valid_q;
    assign cfg_update    = cfg_update_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign err_count     = err_count_q;
    assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

`ifdef HDR_SEQ_TIMEOUT_EN
    logic [7:0] tcnt_q, tcnt_d;
    logic       timeout_hit;

    assign timeout_hit = (tcnt_q == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= 8'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            chk_q        <= '0;
            cfg_q        <= '0;
            cfg_valid_q  <= 1'b0;
            cfg_update_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            chk_q        <= chk_d;
            cfg_q        <= cfg_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_update_q <= cfg_update_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_count_q  <= err_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        chk_d        = chk_q;
        cfg_d        = cfg_q;
        cfg_valid_d  = cfg_valid_q;
        cfg_update_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        err_count_d  = err_count_q;
`ifdef HDR_SEQ_TIMEOUT_EN
        tcnt_d       = tcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hdr_valid) begin
                    chk_d   = hdr_set;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The validator registers its verdict for the new set here.
`ifdef HDR_SEQ_TIMEOUT_EN
                tcnt_d  = 8'd0;
`endif
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (chk_done) begin
                    state_d = S_IDLE;
                    if (chk_valid) begin
                        cfg_d        = chk_q;
                        cfg_valid_d  = 1'b1;
                        cfg_update_d = 1'b1;
                        err_code_d   = 2'b00;
                    end else begin
                        err_d       = 1'b1;
                        err_code_d  = 2'b01;
                        err_count_d = err_count_inc;
                    end
                end
`ifdef HDR_SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = S_IDLE;
                    err_d       = 1'b1;
                    err_code_d  = 2'b10;
                    err_count_d = err_count_inc;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_header_param_sequencer.sv
// Scoreboard bench for header_param_sequencer: a stimulus task pushes the expected
// decision of each set, a negedge monitor pops and compares on cfg_update/err.
`timescale 1ns/1ps
module tb_header_param_sequencer;

    localparam int T = 4;
`ifdef HDR_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        hdr_valid = 0, hdr_ready;
    logic [7:0]  hdr_profile = 0;
    logic [15:0] hdr_width = 0, hdr_height = 0;
    logic [7:0]  hdr_fps = 0;
    logic [1:0]  hdr_chroma_format = 0;
    logic [3:0]  hdr_bit_depth = 0;
    logic [5:0]  hdr_qp = 0;
    logic        hdr_tiles_enabled = 0;
    logic [3:0]  hdr_tile_cols = 0, hdr_tile_rows = 0;
    logic [7:0]  chk_profile, cfg_profile;
    logic [15:0] chk_width, chk_height, cfg_width, cfg_height;
    logic [7:0]  chk_fps, cfg_fps;
    logic [1:0]  chk_chroma_format, cfg_chroma_format;
    logic [3:0]  chk_bit_depth, cfg_bit_depth;
    logic [5:0]  chk_qp, cfg_qp;
    logic        chk_tiles_enabled, cfg_tiles_enabled;
    logic [3:0]  chk_tile_cols, chk_tile_rows, cfg_tile_cols, cfg_tile_rows;
    logic        chk_valid = 0, chk_done = 0;
    logic        cfg_valid, cfg_update, err, busy;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    header_param_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_profile(hdr_profile), .hdr_width(hdr_width), .hdr_height(hdr_height),
        .hdr_fps(hdr_fps), .hdr_chroma_format(hdr_chroma_format),
        .hdr_bit_depth(hdr_bit_depth), .hdr_qp(hdr_qp),
        .hdr_tiles_enabled(hdr_tiles_enabled), .hdr_tile_cols(hdr_tile_cols),
        .hdr_tile_rows(hdr_tile_rows),
        .chk_profile(chk_profile), .chk_width(chk_width), .chk_height(chk_height),
        .chk_fps(chk_fps), .chk_chroma_format(chk_chroma_format),
        .chk_bit_depth(chk_bit_depth), .chk_qp(chk_qp),
        .chk_tiles_enabled(chk_tiles_enabled), .chk_tile_cols(chk_tile_cols),
        .chk_tile_rows(chk_tile_rows),
        .chk_valid(chk_valid), .chk_done(chk_done),
        .cfg_profile(cfg_profile), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_fps(cfg_fps), .cfg_chroma_format(cfg_chroma_format),
        .cfg_bit_depth(cfg_bit_depth), .cfg_qp(cfg_qp),
        .cfg_tiles_enabled(cfg_tiles_enabled), .cfg_tile_cols(cfg_tile_cols),
        .cfg_tile_rows(cfg_tile_rows),
        .cfg_valid(cfg_valid), .cfg_update(cfg_update), .err(err),
        .err_code(err_code), .err_count(err_count), .busy(busy)
    );

    logic [68:0] chk_bus, cfg_bus;
    assign chk_bus = {chk_profile, chk_width, chk_height, chk_fps, chk_chroma_format,
                      chk_bit_depth, chk_qp, chk_tiles_enabled, chk_tile_cols, chk_tile_rows};
    assign cfg_bus = {cfg_profile, cfg_width, cfg_height, cfg_fps, cfg_chroma_format,
                      cfg_bit_depth, cfg_qp, cfg_tiles_enabled, cfg_tile_cols, cfg_tile_rows};

    typedef struct {
        bit          is_err;
        logic [68:0] cfg;
        bit          cfgv;
        logic [1:0]  code;
        logic [7:0]  cnt;
        int          at;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [68:0] m_cfg = '0;
    bit          m_cfgv = 0;
    int          m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (cfg_update || err)) begin
            if (q.size() == 0) begin
                check("unexpected_event", {cfg_update, err}, 2'b00);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind", {cfg_update, err}, e.is_err ? 2'b01 : 2'b10);
                check("event_cycle", cyc, e.at);
                check("cfg_bus", cfg_bus, e.cfg);
                check("cfg_valid", cfg_valid, e.cfgv);
                check("err_code", err_code, e.code);
                check("err_count", err_count, e.cnt);
            end
        end
    end

    // d = CHECK cycles before chk_done rises; d < 0 means the validator never answers.
    task automatic send(input logic [68:0] s, input bit ok, input int d, input bit hold, input bit junk);
        int   c0, n, dec;
        bit   tmo;
        exp_t e;
        {hdr_profile, hdr_width, hdr_height, hdr_fps, hdr_chroma_format,
         hdr_bit_depth, hdr_qp, hdr_tiles_enabled, hdr_tile_cols, hdr_tile_rows} = s;
        hdr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!hdr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", hdr_ready, 1'b1);
        if (hold) check("b2b_accept_wait", n, 0);
        c0  = cyc;
        tmo = TO_EN && (d < 0 || d > T);
        dec = tmo ? T : d;
        e.at = c0 + 3 + dec;
        if (tmo || !ok) begin
            m_cnt    = (m_cnt >= 255) ? 255 : m_cnt + 1;
            e.is_err = 1'b1;
            e.code   = tmo ? 2'b10 : 2'b01;
        end else begin
            m_cfg    = s;
            m_cfgv   = 1'b1;
            e.is_err = 1'b0;
            e.code   = 2'b00;
        end
        e.cfg  = m_cfg;
        e.cfgv = m_cfgv;
        e.cnt  = 8'(m_cnt);
        q.push_back(e);
        @(posedge clk); #1;
        if (!hold) hdr_valid = 1'b0;
        if (junk) begin
            chk_done  = 1'b1;
            chk_valid = 1'($urandom);
        end
        @(negedge clk);
        check("settle_ready_busy", {hdr_ready, busy}, 2'b01);
        @(posedge clk); #1;
        for (int k = 0; k <= dec; k++) begin
            chk_done  = (k == d);
            chk_valid = ok;
            @(negedge clk);
            if (k == 0) check("chk_bus", chk_bus, s);
            check("check_ready_busy", {hdr_ready, busy}, 2'b01);
            @(posedge clk); #1;
        end
        chk_done  = 1'b0;
        chk_valid = 1'($urandom);
        hdr_valid = 1'b0;
    endtask

    function automatic logic [68:0] rnd_set();
        return 69'({$urandom(), $urandom(), $urandom()});
    endfunction

    logic [68:0] set_a, set_b;

    initial begin
        #12;
        check("reset_outputs",
              {chk_bus, cfg_bus, cfg_valid, cfg_update, err, err_code, err_count, hdr_ready, busy},
              {69'd0, 69'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b1, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        set_a = {8'd1, 16'd1920, 16'd1088, 8'd30, 2'd1, 4'd8, 6'd30, 1'b0, 4'd0, 4'd0};
        send(set_a, 1'b1, 0, 1'b0, 1'b0);
        check("cfg_width_1920", cfg_width, 16'd1920);
        check("err_count_zero", err_count, 8'd0);

        set_b = rnd_set();
        send(set_b, 1'b0, 1, 1'b0, 1'b1);
        check("cfg_still_a", cfg_bus, set_a);

`ifdef HDR_SEQ_TIMEOUT_EN
        send(rnd_set(), 1'b1, -1, 1'b0, 1'b0);
        send(rnd_set(), 1'b1, T, 1'b0, 1'b0);
`else
        send(rnd_set(), 1'b1, 20, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++)
            send(rnd_set(), 1'($urandom), int'($urandom_range(0, T + 2)),
                 1'($urandom), 1'($urandom));

        for (int i = 0; i < 3; i++)
            send(rnd_set(), 1'b1, 0, 1'b1, 1'b0);

        for (int i = 0; i < 256; i++)
            send(rnd_set(), 1'b0, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        check("err_count_saturated", err_count, 8'd255);

        // Reset while a set is in CHECK.
        {hdr_profile, hdr_width, hdr_height, hdr_fps, hdr_chroma_format,
         hdr_bit_depth, hdr_qp, hdr_tiles_enabled, hdr_tile_cols, hdr_tile_rows} = rnd_set();
        hdr_valid = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        @(posedge clk); #1;
        chk_done = 1'b0;
        @(posedge clk); #2;
        check("in_check_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {chk_bus, cfg_bus, cfg_valid, cfg_update, err, err_code, err_count, hdr_ready, busy},
              {69'd0, 69'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b1, 1'b0});
        m_cfg = '0; m_cfgv = 0; m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        chk_done = 1'b1; chk_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_done = 1'b0;
        send(rnd_set(), 1'b1, 1, 1'b0, 1'b0);
        send(rnd_set(), 1'b0, 0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check("pending_events", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", q.size());
        $fatal(1);
    end

endmodule
